// File: rtl/atomic_region_monitor.sv
// atomic_region_monitor: PC-tracking monitor that enforces atomic, entry/exit-controlled
// execution of up to four protected code regions and requests a core reset on violation.
//   clk, reset_n          clock, asynchronous active-low reset
//   pc, irq, dma_en       sampled core activity
//   res                   registered reset request to the core
//   viol, viol_cause      one-cycle violation pulse, sticky cause of the last violation
//   viol_count            saturating violation count
//   in_region, active_region  ATOMIC indicator and current region index
module atomic_region_monitor #(
    parameter int                    N_REGIONS     = 2,
    parameter logic [N_REGIONS*16-1:0] FST_ADDRS   = {16'hB000, 16'hA000},
    parameter logic [N_REGIONS*16-1:0] LST_ADDRS   = {16'hB03E, 16'hA0FE},
    parameter logic [15:0]           RESET_HANDLER = 16'hFFFE,
    parameter int                    HOLD_CYCLES   = 4,
    parameter bit                    IRQ_ALLOWED   = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] pc,
    input  logic        irq,
    input  logic        dma_en,
    output logic        res,
    output logic        viol,
    output logic [2:0]  viol_cause,
    output logic [7:0]  viol_count,
    output logic        in_region,
    output logic [1:0]  active_region
);
    typedef enum logic [1:0] {KILL, RUN, ATOMIC} state_t;
    state_t      state_q, state_d;
    logic [7:0]  hold_q, hold_d, cnt_q, cnt_d;
    logic [2:0]  cause_q, cause_d, cause;
    logic [1:0]  reg_q, reg_d, h;
    logic        lst_q, lst_d, res_q, res_d, viol_q, viol_d;
    logic        h_hit, h_fst, h_one, in_a, a_lst;
    // h is the lowest-index region containing pc; in_a/a_lst describe the active region
    always_comb begin
        h     = '0;
        h_hit = 1'b0;
        h_fst = 1'b0;
        h_one = 1'b0;
        in_a  = 1'b0;
        a_lst = 1'b0;
        for (int r = N_REGIONS - 1; r >= 0; r--) begin
            logic [15:0] f, l;
            logic        hh;
            f  = FST_ADDRS[16*r +: 16];
            l  = LST_ADDRS[16*r +: 16];
            hh = pc >= f && pc <= l;
            if (hh) begin
                h     = 2'(r);
                h_hit = 1'b1;
                h_fst = pc == f;
                h_one = f == l;
            end
            if (2'(r) == reg_q) begin
                in_a  = hh;
                a_lst = pc == l;
            end
        end
    end
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        lst_d   = lst_q;
        reg_d   = reg_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        cause   = 3'd0;
        case (state_q)
            KILL: begin
                hold_d = hold_q == 8'd0 ? 8'd0 : hold_q - 8'd1;
                if (hold_q == 8'd0 && pc == RESET_HANDLER) state_d = RUN;
            end
            RUN: begin
                if (h_hit && h_fst) begin
                    state_d = ATOMIC;
                    reg_d   = h;
                    lst_d   = h_one;
                end else if (h_hit) begin
                    cause = 3'd1;
                end
            end
            ATOMIC: begin
                if (in_a) begin
                    lst_d = a_lst;
                end else if (lst_q && h_hit && h_fst) begin
                    reg_d = h;
                    lst_d = h_one;
                end else if (lst_q) begin
                    state_d = RUN;
                end else begin
                    cause = 3'd2;
                end
                if (cause == 3'd0 && irq && !IRQ_ALLOWED) cause = 3'd3;
                else if (cause == 3'd0 && dma_en) cause = 3'd4;
            end
            default: state_d = KILL;
        endcase
        if (cause != 3'd0) begin
            state_d = KILL;
            hold_d  = 8'(HOLD_CYCLES - 1);
            cause_d = cause;
            cnt_d   = cnt_q == 8'hFF ? 8'hFF : cnt_q + 8'd1;
        end
        viol_d = cause != 3'd0;
        res_d  = state_d == KILL;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= KILL;
            hold_q  <= 8'(HOLD_CYCLES - 1);
            lst_q   <= 1'b0;
            reg_q   <= '0;
            cause_q <= '0;
            cnt_q   <= '0;
            res_q   <= 1'b1;
            viol_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            lst_q   <= lst_d;
            reg_q   <= reg_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            viol_q  <= viol_d;
        end
    end
    assign res           = res_q;
    assign viol          = viol_q;
    assign viol_cause    = cause_q;
    assign viol_count    = cnt_q;
    assign in_region     = state_q == ATOMIC;
    assign active_region = reg_q;
endmodule

// File: doc/atomic_region_monitor.md
# atomic_region_monitor

Parametrised PC-tracking monitor that enforces atomic, entry-and-exit-controlled execution of up to four protected code regions. It drives a system reset request on any violation. It sits beside the openMSP430 core, samples the program counter, interrupt and DMA activity every cycle, and generalises the single-region proof-of-reset monitor. It adds multiple regions, interrupt and DMA policing, a minimum reset-hold time, and violation reporting.

## Interface

Parameters:
- N_REGIONS, 2, number of protected regions (1..4).
- FST_ADDRS, {16'hB000,16'hA000}, N_REGIONS×16 flattened vector; region r entry address in bits [16r+15:16r].
- LST_ADDRS, {16'hB03E,16'hA0FE}, N_REGIONS×16 flattened vector; region r last instruction address (FST ≤ LST).
- RESET_HANDLER, 16'hFFFE, PC value that releases the KILL state.
- HOLD_CYCLES, 4, minimum cycles res stays high after entering KILL (1..255).
- IRQ_ALLOWED, 0, when 1 an interrupt inside a region is not a violation.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pc  in  16  current program counter.
- irq  in  1  interrupt being serviced this cycle.
- dma_en  in  1  DMA bus access this cycle.
- res  out  1  reset request to the core, registered.
- viol  out  1  one-cycle pulse on each detected violation.
- viol_cause  out  3  cause of the last violation (sticky).
- viol_count  out  8  saturating count of violations.
- in_region  out  1  high while in ATOMIC.
- active_region  out  2  index of the current region, valid when in_region=1.

## Operation

- Reset (reset_n=0, asynchronous) sets the following:
  - state = KILL, res = 1, hold_cnt = HOLD_CYCLES-1, lst_flag = 0.
  - viol = 0, viol_cause = 0, viol_count = 0.
  - in_region = 0, active_region = 0.
- Region hit test: pc ∈ [FST_r, LST_r] inclusive. On overlapping regions, the lowest index wins.
- States: KILL, RUN, ATOMIC.
- KILL behaviour:
  - res = 1.
  - hold_cnt decrements to 0 and stops there.
  - Moves to RUN when hold_cnt == 0 and pc == RESET_HANDLER.
  - All violation checks are disabled in this state.
- RUN behaviour:
  - res = 0.
  - pc == FST_r goes to ATOMIC with active_region = r and lst_flag = (FST_r == LST_r).
  - pc inside region r but ≠ FST_r is a bad entry, cause 3'd1.
- ATOMIC behaviour, region a:
  - pc inside a keeps the state; lst_flag <= (pc == LST_a).
  - pc outside a with lst_flag = 1 is a legal exit. The next state is ATOMIC(r) if pc == FST_r of another region, otherwise RUN.
  - Any other pc outside a is a bad exit, cause 3'd2.
  - irq = 1 with IRQ_ALLOWED = 0 is cause 3'd3.
  - dma_en = 1 is cause 3'd4.
- Simultaneous causes: priority bad entry/exit > irq > dma. Only one cause is recorded.
- On violation:
  - Next state = KILL, res <= 1, hold_cnt <= HOLD_CYCLES-1.
  - viol <= 1 for one cycle; viol_cause <= cause.
  - viol_count <= viol_count+1, saturating at 8'hFF.
- viol_cause and viol_count are cleared only by reset_n.

## Timing

- Single-cycle decision: inputs sampled at edge k produce state, res and viol at edge k+1.
- Violation to res high: 1 cycle.
- Minimum res-high duration: HOLD_CYCLES cycles.
- KILL exit: if pc == RESET_HANDLER throughout, res falls HOLD_CYCLES cycles after entering KILL.
- After a legal exit, in_region falls 1 cycle after pc leaves the region.
- Region-to-region chaining (LST_a followed directly by FST_b) keeps in_region high, and active_region updates in 1 cycle.
- reset_n assertion mid-ATOMIC returns all outputs to their reset values immediately, asynchronously.
- reset_n is released synchronously to clk by the system.

## Test plan

1. Release reset with pc = 16'hFFFE held. Required: res = 1 for 4 cycles, then 0; viol_count = 0.
2. From RUN, sequence pc A000, A002, A0FE, C000. Required:
   - in_region = 1 with active_region = 0 during the region.
   - Returns to RUN; res stays 0; no viol.
3. From RUN, pc jumps to A010. Required: viol pulse, viol_cause = 1, res = 1 next cycle, viol_count = 1.
4. Inside region 0 at A002, pc goes to C000. Required: viol_cause = 2 and res = 1. Separately, irq = 1 at A004 gives cause 3; with irq and dma_en both high, cause 3 is recorded.
5. Sequence pc A0FE then B000. Required: active_region changes 0 → 1, in_region stays 1, no viol. Then dma_en = 1 gives cause 4.
6. Force 256 violations. Required: viol_count saturates at 8'hFF. Assert reset_n = 0 mid-ATOMIC: res = 1 and all counters clear without waiting for a clock.
